// File: rtl/abejaruco_mem_pkg.sv
// Shared defaults, FSM state type and helpers for the memory port arbiter.
package abejaruco_mem_pkg;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_LINE_WIDTH    = 128;
    localparam int DEF_STARVE_LIMIT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IC,
        GRANT_DC,
        RESPOND
    } arb_state_e;

    // Two-bit counter that sticks at its maximum instead of wrapping.
    function automatic logic [1:0] sat_inc(input logic [1:0] value);
        return (value == 2'd3) ? value : value + 2'd1;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// I-cache, D-cache and main-memory handshake bundle for the memory port arbiter.
interface memory_port_arbiter_if
    import abejaruco_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int LINE_WIDTH    = DEF_LINE_WIDTH
) ();

    logic                     ic_req;
    logic [ADDRESS_WIDTH-1:0] ic_addr;
    logic                     ic_ready;
    logic [LINE_WIDTH-1:0]    ic_line;

    logic                     dc_req;
    logic                     dc_we;
    logic [ADDRESS_WIDTH-1:0] dc_addr;
    logic [LINE_WIDTH-1:0]    dc_wline;
    logic                     dc_ready;
    logic [LINE_WIDTH-1:0]    dc_line;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0]    mem_wline;
    logic                     mem_ready;
    logic [LINE_WIDTH-1:0]    mem_rline;

    logic                     busy;

    // The arbiter side.
    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wline,
        input  mem_ready, mem_rline,
        output ic_ready, ic_line,
        output dc_ready, dc_line,
        output mem_req, mem_we, mem_addr, mem_wline,
        output busy
    );

    // The caches plus main memory, i.e. everything around the arbiter.
    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wline,
        output mem_ready, mem_rline,
        input  ic_ready, ic_line,
        input  dc_ready, dc_line,
        input  mem_req, mem_we, mem_addr, mem_wline,
        input  busy
    );

endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache; D wins by
// default, I wins once it has watched STARVE_LIMIT consecutive D-grants.
module memory_port_arbiter
    import abejaruco_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int LINE_WIDTH    = DEF_LINE_WIDTH,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input logic                   clk,
    input logic                   rst,
    memory_port_arbiter_if.slave  bus
);

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = '0;
    localparam logic [LINE_WIDTH-1:0]    ZERO_LINE = '0;

    arb_state_e state;
    logic [1:0] starve_cnt;
    logic       ic_wins;

    assign ic_wins = bus.ic_req && (int'(starve_cnt) >= STARVE_LIMIT);

    // The mem_* registers double as the latched request: they are loaded on
    // the grant edge and stay frozen until mem_ready, so later input changes
    // from the requester cannot leak into an open transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= 2'd0;
            bus.busy      <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ZERO_ADDR;
            bus.mem_wline <= ZERO_LINE;
            bus.ic_ready  <= 1'b0;
            bus.ic_line   <= ZERO_LINE;
            bus.dc_ready  <= 1'b0;
            bus.dc_line   <= ZERO_LINE;
        end else begin
            // NOTE: every assignment here is non-blocking so all registers
            // sample the same pre-edge values; a blocking '=' would let later
            // lines see already-updated state within the same edge.
            case (state)
                IDLE: begin
                    if (bus.dc_req && !ic_wins) begin
                        state         <= GRANT_DC;
                        bus.busy      <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.dc_we;
                        bus.mem_addr  <= bus.dc_addr;
                        bus.mem_wline <= bus.dc_wline;
                        starve_cnt    <= bus.ic_req ? sat_inc(starve_cnt) : 2'd0;
                    end else if (bus.ic_req) begin
                        state         <= GRANT_IC;
                        bus.busy      <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.ic_addr;
                        bus.mem_wline <= ZERO_LINE;
                        starve_cnt    <= 2'd0;
                    end
                end

                GRANT_IC, GRANT_DC: begin
                    if (bus.mem_ready) begin
                        state         <= RESPOND;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= ZERO_ADDR;
                        bus.mem_wline <= ZERO_LINE;
                        if (state == GRANT_DC) begin
                            // A completed write-back returns an all-zero line.
                            bus.dc_ready <= 1'b1;
                            bus.dc_line  <= bus.mem_we ? ZERO_LINE : bus.mem_rline;
                        end else begin
                            bus.ic_ready <= 1'b1;
                            bus.ic_line  <= bus.mem_rline;
                        end
                    end
                end

                RESPOND: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.ic_ready <= 1'b0;
                    bus.ic_line  <= ZERO_LINE;
                    bus.dc_ready <= 1'b0;
                    bus.dc_line  <= ZERO_LINE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
